// File: rtl/jk_cmd_pkg.sv
// ============================================================================
//  Module      : jk_cmd_pkg
//  Description : Shared opcode encodings and FSM state type for jk_cmd_arbiter
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package jk_cmd_pkg;

    // Opcode bits are ordered {j, k} so they map straight onto the JK inputs
    localparam logic [1:0] OP_HOLD = 2'b00;
    localparam logic [1:0] OP_RST  = 2'b01;
    localparam logic [1:0] OP_SET  = 2'b10;
    localparam logic [1:0] OP_TGL  = 2'b11;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        APPLY = 1'b1
    } state_t;

endpackage

`default_nettype wire

// File: rtl/jk_ff.sv
// ============================================================================
//  Module      : jk_ff
//  Description : Single edge-triggered JK flip-flop, async active-low clear
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_ff (
    input  logic clk,
    input  logic rst_n,
    input  logic j,
    input  logic k,
    output logic q
);

    logic r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= 1'b0;
        end else begin
            case ({j, k})
                2'b01:   r_q <= 1'b0;
                2'b10:   r_q <= 1'b1;
                2'b11:   r_q <= ~r_q;
                default: r_q <= r_q;
            endcase
        end
    end

    assign q = r_q;

endmodule

`default_nettype wire

// File: rtl/jk_cmd_arbiter.sv
// ============================================================================
//  Module      : jk_cmd_arbiter
//  Description : Round-robin arbiter issuing single-bit JK commands to a bank
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module jk_cmd_arbiter
    import jk_cmd_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int AW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req,
    input  logic [NREQ*AW-1:0]   addr,
    input  logic [NREQ*2-1:0]    op,
    output logic [NREQ-1:0]      gnt,
    output logic [WIDTH-1:0]     q,
    output logic                 busy,
    output logic                 err
);

    localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

    state_t            r_state;
    logic [PW-1:0]     r_ptr;
    logic [PW-1:0]     r_win;
    logic [AW-1:0]     r_addr;
    logic [1:0]        r_op;
    logic [NREQ-1:0]   r_gnt;
    logic              r_busy;
    logic              r_err;

    logic [PW-1:0]     w_win;
    logic              w_found;
    logic [PW:0]       w_idx;
    logic [AW-1:0]     w_sel_addr;
    logic [WIDTH-1:0]  w_j;
    logic [WIDTH-1:0]  w_k;

    // First requester at or above r_ptr, wrapping past NREQ-1 back to 0
    always_comb begin
        w_win   = r_ptr;
        w_found = 1'b0;
        w_idx   = '0;
        for (int n = 0; n < NREQ; n++) begin
            w_idx = {1'b0, r_ptr} + (PW+1)'(n);
            if (w_idx >= (PW+1)'(NREQ)) begin
                w_idx = w_idx - (PW+1)'(NREQ);
            end
            if (!w_found && req[w_idx[PW-1:0]]) begin
                w_found = 1'b1;
                w_win   = w_idx[PW-1:0];
            end
        end
    end

    assign w_sel_addr = addr[w_win*AW +: AW];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_ptr   <= '0;
            r_win   <= '0;
            r_addr  <= '0;
            r_op    <= OP_HOLD;
            r_gnt   <= '0;
            r_busy  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_win   <= w_win;
                        r_addr  <= w_sel_addr;
                        r_op    <= op[w_win*2 +: 2];
                        r_gnt   <= NREQ'(1) << w_win;
                        r_busy  <= 1'b1;
                        r_err   <= (int'(w_sel_addr) >= WIDTH);
                        r_state <= APPLY;
                    end
                end
                APPLY: begin
                    r_gnt   <= '0;
                    r_busy  <= 1'b0;
                    r_err   <= 1'b0;
                    r_ptr   <= (r_win == PW'(NREQ-1)) ? '0 : r_win + PW'(1);
                    r_state <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    // Out-of-range addresses match no bit, so the bank is left untouched
    always_comb begin
        w_j = '0;
        w_k = '0;
        if (r_state == APPLY) begin
            for (int b = 0; b < WIDTH; b++) begin
                if (int'(r_addr) == b) begin
                    case (r_op)
                        OP_RST:  w_k[b] = 1'b1;
                        OP_SET:  w_j[b] = 1'b1;
                        OP_TGL: begin
                            w_j[b] = 1'b1;
                            w_k[b] = 1'b1;
                        end
                        default: begin
                            w_j[b] = 1'b0;
                            w_k[b] = 1'b0;
                        end
                    endcase
                end
            end
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bits
        jk_ff u_ff (
            .clk   (clk),
            .rst_n (rst_n),
            .j     (w_j[i]),
            .k     (w_k[i]),
            .q     (q[i])
        );
    end

    assign gnt  = r_gnt;
    assign busy = r_busy;
    assign err  = r_err;

endmodule

`default_nettype wire

// File: tb/tb_jk_cmd_arbiter.sv
// ============================================================================
//  Module      : tb_jk_cmd_arbiter
//  Description : Scoreboard bench for jk_cmd_arbiter against a command model
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_jk_cmd_arbiter;
    import jk_cmd_pkg::*;

    localparam int NREQ  = 4;
    localparam int WIDTH = 6;
    localparam int AW    = 3;

    logic                clk   = 1'b0;
    logic                rst_n = 1'b0;
    logic [NREQ-1:0]     req   = '0;
    logic [NREQ*AW-1:0]  addr  = '0;
    logic [NREQ*2-1:0]   op    = '0;
    logic [NREQ-1:0]     gnt;
    logic [WIDTH-1:0]    q;
    logic                busy;
    logic                err;

    jk_cmd_arbiter #(
        .NREQ  (NREQ),
        .WIDTH (WIDTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .req   (req),
        .addr  (addr),
        .op    (op),
        .gnt   (gnt),
        .q     (q),
        .busy  (busy),
        .err   (err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NREQ-1:0]  gnt;
        logic             err;
        logic [WIDTH-1:0] q;
    } exp_t;

    exp_t              sb[$];
    int                n_tests = 0;
    int                n_fail  = 0;
    bit                sb_on   = 1'b0;

    // Requester-side pending commands and the reference bank
    bit [NREQ-1:0]     pv = '0;
    int                pa[NREQ];
    int                po[NREQ];
    int                m_ptr   = 0;
    bit                m_apply = 1'b0;
    bit [WIDTH-1:0]    m_q     = '0;
    bit                repost  = 1'b0;
    bit                rnd     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic post(input int i, input int a, input int o);
        pv[i] = 1'b1;
        pa[i] = a;
        po[i] = o;
    endtask

    task automatic new_cmd(input int i, input int amax);
        post(i, int'($urandom_range(0, amax)), int'($urandom_range(0, 3)));
    endtask

    task automatic drive();
        for (int i = 0; i < NREQ; i++) begin
            req[i]            = pv[i];
            addr[i*AW +: AW]  = AW'(pa[i]);
            op[i*2 +: 2]      = 2'(po[i]);
        end
    endtask

    // Advance the model over the edge just taken, using what was on the pins
    task automatic step();
        int   w;
        int   a;
        exp_t e;
        @(posedge clk);
        #1;
        if (m_apply) begin
            m_apply = 1'b0;
        end else if (req != '0) begin
            w = -1;
            for (int n = 0; n < NREQ; n++) begin
                if (w < 0 && req[(m_ptr + n) % NREQ]) w = (m_ptr + n) % NREQ;
            end
            a = int'(addr[w*AW +: AW]);
            e.gnt    = '0;
            e.gnt[w] = 1'b1;
            e.err    = (a >= WIDTH);
            if (!e.err) begin
                case (op[w*2 +: 2])
                    OP_RST:  m_q[a] = 1'b0;
                    OP_SET:  m_q[a] = 1'b1;
                    OP_TGL:  m_q[a] = ~m_q[a];
                    default: m_q[a] = m_q[a];
                endcase
            end
            e.q = m_q;
            sb.push_back(e);
            m_ptr   = (w + 1) % NREQ;
            m_apply = 1'b1;
            pv[w]   = 1'b0;
            if (repost) new_cmd(w, WIDTH - 1);
        end
        if (rnd) begin
            for (int i = 0; i < NREQ; i++) begin
                if (!pv[i] && $urandom_range(0, 1) == 1) new_cmd(i, 7);
            end
        end
        drive();
    endtask

    task automatic drain();
        rnd    = 1'b0;
        repost = 1'b0;
        for (int n = 0; n < 60 && (pv != '0 || m_apply); n++) step();
        check("drain_timeout", {31'd0, (pv != '0 || m_apply)}, 32'd0);
        step();
        step();
    endtask

    // Monitor: pops one expectation per grant pulse, then checks the bank next cycle
    initial begin
        exp_t           e;
        bit             qchk = 1'b0;
        logic [WIDTH-1:0] qexp = '0;
        forever begin
            @(negedge clk);
            if (!sb_on) begin
                qchk = 1'b0;
                continue;
            end
            if (qchk) begin
                check("q_after_apply", q, qexp);
                check("busy_one_cycle", busy, 1'b0);
                check("gnt_one_cycle", gnt, '0);
                qchk = 1'b0;
            end else if (gnt != '0 || busy || err) begin
                if (sb.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_grant: got gnt=%b busy=%b err=%b expected none", gnt, busy, err);
                end else begin
                    e = sb.pop_front();
                    check("gnt", gnt, e.gnt);
                    check("busy", busy, 1'b1);
                    check("err", err, e.err);
                    qexp = e.q;
                    qchk = 1'b1;
                end
            end
        end
    end

    initial begin
        for (int i = 0; i < NREQ; i++) begin
            pa[i] = 0;
            po[i] = 0;
        end
        repeat (3) @(posedge clk);
        #1;
        check("reset_gnt", gnt, '0);
        check("reset_busy", busy, 1'b0);
        check("reset_err", err, 1'b0);
        check("reset_q", q, '0);
        @(negedge clk);
        rst_n = 1'b1;
        sb_on = 1'b1;

        post(0, 3, OP_SET); drain();
        post(0, 3, OP_RST); drain();
        post(2, 5, OP_TGL); drain();
        post(2, 5, OP_TGL); drain();
        post(2, 5, OP_HOLD); drain();

        post(3, 0, OP_HOLD); drain();
        repost = 1'b1;
        for (int i = 0; i < NREQ; i++) post(i, i, OP_SET);
        repeat (16) step();
        drain();

        post(1, 2, OP_TGL); drain();
        post(0, 1, OP_SET); post(1, 1, OP_TGL); drain();

        post(1, 7, OP_SET); drain();
        post(2, 6, OP_TGL); drain();

        rnd = 1'b1;
        repeat (300) step();
        drain();

        post(0, 2, OP_SET); drain();
        check("scoreboard_empty", sb.size(), 0);
        sb_on = 1'b0;

        // Reset while requester 0 is mid-APPLY; arbitration must restart at requester 0
        req            = 4'b0001;
        addr[0 +: AW]  = 3'd1;
        op[0 +: 2]     = OP_SET;
        @(posedge clk);
        #1;
        check("pre_reset_gnt", gnt, 4'b0001);
        #2;
        rst_n = 1'b0;
        #1;
        check("mid_reset_gnt", gnt, '0);
        check("mid_reset_busy", busy, 1'b0);
        check("mid_reset_q", q, '0);
        req             = 4'b0011;
        addr[AW +: AW]  = 3'd1;
        op[2 +: 2]      = OP_SET;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("post_reset_first", gnt, 4'b0001);
        req = 4'b0010;
        @(posedge clk);
        #1;
        check("post_reset_q", q, 6'h02);
        @(posedge clk);
        #1;
        check("post_reset_second", gnt, 4'b0010);
        req = '0;
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/jk_cmd_arbiter.md
# jk_cmd_arbiter

Shares one bank of edge-triggered JK flip-flops between several requesters. Each requester posts a single-bit command (hold, reset, set, toggle) for one bank bit. The block picks one requester per command slot with round-robin arbitration, then drives J/K onto the addressed bit for exactly one clock edge. It sits between the stimulus/control logic and the JK storage, and it is the only writer of that storage.

## Interface
Parameters:
- NREQ, 4: number of requesters (2..8)
- WIDTH, 8: bank width in bits (1..16)
- AW, $clog2(WIDTH) (minimum 1): per-requester address width (derived)

Ports:
- clk, input, 1: single clock, rising edge
- rst_n, input, 1: asynchronous active-low reset
- req, input, NREQ: request per requester; held high until granted
- addr, input, NREQ*AW: packed bit addresses; requester i uses slice [i*AW +: AW]
- op, input, NREQ*2: packed opcodes; requester i uses [i*2 +: 2]; 00 hold, 01 reset, 10 set, 11 toggle
- gnt, output, NREQ: one-hot, one-cycle grant pulse
- q, output, WIDTH: JK bank state
- busy, output, 1: high while a command is in flight (APPLY)
- err, output, 1: one-cycle pulse when the granted address is >= WIDTH

## Operation
- FSM has two states, IDLE and APPLY.
- IDLE: if req is nonzero, select the winner. Search starts at rr_ptr and proceeds upward with wrap. Latch the winner's index, addr and op, then go to APPLY. If req is zero, stay in IDLE.
- APPLY: gnt[winner]=1, busy=1. Drive j/k for the addressed bit from the latched op: hold 0/0, reset 0/1, set 1/0, toggle 1/1. All other bits get j=k=0. Set rr_ptr to (winner+1) mod NREQ. Return to IDLE.
- Out-of-range address: grant proceeds and err=1 in APPLY, but no bit changes.
- Hold op: grant is issued and q is unchanged.
- req and addr/op are sampled only at the IDLE→APPLY edge. Changes during APPLY are ignored.
- A requester must drop req (or present a new command) in the cycle after its gnt. A req still high after gnt is treated as a new command.
- Reset values (asynchronous, immediate): state IDLE, rr_ptr 0, q all 0, gnt 0, busy 0, err 0.

## Timing
- Latency: req high at edge N in IDLE gives the APPLY cycle between N and N+1 (gnt, busy, err valid). q reflects the command after edge N+1.
- Throughput: one command per 2 cycles. With continuous requests, IDLE and APPLY alternate.
- Simultaneous requests: round-robin from rr_ptr. No requester waits more than NREQ-1 other grants.
- Reset asserted during APPLY: the command is dropped, q is cleared, gnt is deasserted immediately, and rr_ptr returns to 0.
- Reset deassertion: the first arbitration happens at the first rising edge with rst_n high.
- gnt, busy and err are registered outputs; there is no combinational path from req.

## Structure
- Package jk_cmd_pkg:
  - op encodings OP_HOLD, OP_RST, OP_SET, OP_TGL
  - state enum {IDLE, APPLY}
- Sub-module jk_ff:
  - one edge-triggered JK flip-flop with async active-low reset (q=0)
  - instantiated WIDTH times with a generate loop
  - behaviour at rising edge: j/k 00 hold, 01 → 0, 10 → 1, 11 → invert
- Top level contains the FSM, the round-robin selector, the command latch and the J/K decode.

## Test plan
- Reset then single set: req[0]=1, addr0=3, op0=10. gnt=0001 one cycle later; q=0x08 after the following edge. busy high for exactly 1 cycle.
- Toggle twice: requester 2 toggles bit 5 twice. q goes 0x00→0x20→0x00. Hold op on bit 5 leaves q=0x00 with gnt[2] pulsed.
- Contention: req=1111 held, each requester re-asserting after gnt. Grants sequence 0001,0010,0100,1000,0001, one every 2 cycles.
- Pointer fairness: rr_ptr=2, req=0011. Grant goes to 0 first, then 1.
- Out of range: WIDTH=6, addr=7, op=set. gnt pulses, err=1 same cycle, q unchanged.
- Reset mid-op: rst_n low during APPLY of set bit 1. gnt drops immediately, q stays 0x00, the next command is arbitrated from requester 0.
